fifo_reader: RTL and testbench

- Dequeue-side controller for the team's 8-deep byte FIFO.
- On a start command it drains a counted burst, or drains until the FIFO is empty.
- It issues one-cycle dequeue strobes and captures the FIFO output word.
- Each word is presented to a downstream consumer over a valid/ready handshake, with busy/done status for a host controller.

---
 rtl/fifo_reader_pkg.sv | 17 +
 rtl/fifo_reader_hold.sv | 70 +++++++
 rtl/fifo_reader.sv | 123 ++++++++++++
 tb/tb_fifo_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizes for the fifo_reader dequeue controller.
package fifo_reader_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_LEN_W       = 4;
  localparam int UNTIL_EMPTY_LEN = 0;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    CAPTURE,
    PRESENT,
    FINISH
  } state_t;

endpackage

// File: rtl/fifo_reader_hold.sv
// Output holding register for fifo_reader: delivered word, valid flag and,
// when FIFO_READER_PARITY_EN is defined, the word's parity.
module fifo_reader_hold
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // The word stays in data_q after a handshake; only the valid flag drops.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef FIFO_READER_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = ^load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: rtl/fifo_reader.sv
// Dequeue-side controller: drains a counted burst or until empty from an 8-deep
// byte FIFO. Defining FIFO_READER_PARITY_EN adds the out_parity output.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              fifo_empty,
  output logic              fifo_deq,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  drained
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] drained_q, drained_d;
  logic             counted_q, counted_d;
  logic             hold_load, hold_clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      drained_q   <= '0;
      counted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drained_q   <= drained_d;
      counted_q   <= counted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drained_d   = drained_q;
    counted_d   = counted_q;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = len;
          counted_d   = (len != LEN_W'(UNTIL_EMPTY_LEN));
          drained_d   = '0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        // Counted bursts wait for data; until-empty bursts end on an empty FIFO.
        if (counted_q && (remaining_q == '0)) begin
          state_d = FINISH;
        end else if (fifo_empty) begin
          state_d = counted_q ? CHECK : FINISH;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        hold_load = 1'b1;
        state_d   = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          hold_clear = 1'b1;
          if (drained_q != '1) begin
            drained_d = drained_q + LEN_W'(1);
          end
          if (counted_q) begin
            remaining_d = remaining_q - LEN_W'(1);
          end
          state_d = CHECK;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_deq = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign drained  = drained_q;

  fifo_reader_hold #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_data (fifo_data),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef FIFO_READER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a queue-based FIFO and consumer model
// drive directed and random bursts. Define FIFO_READER_PARITY_EN to cover out_parity.
`timescale 1ns/1ps
module tb_fifo_reader;

  localparam int DATA_W  = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 3000;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              start      = 1'b0;
  logic [LEN_W-1:0]  len        = '0;
  logic              fifo_empty = 1'b1;
  logic              fifo_deq;
  logic [DATA_W-1:0] fifo_data  = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready  = 1'b0;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  drained;
`ifdef FIFO_READER_PARITY_EN
  logic              out_parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] refill_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              par_q[$];
  logic              refill_en   = 1'b0;
  int                ready_force = 1;
  int cyc = 0, start_cyc = -1, first_deq_cyc = -1, first_valid_cyc = -1;
  int deq_count = 0, done_count = 0, underflow = 0, unstable = 0, exp_left = 0;
  logic              held      = 1'b0;
  logic [DATA_W-1:0] held_data = '0;

  fifo_reader #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .fifo_empty(fifo_empty),
    .fifo_deq  (fifo_deq),
    .fifo_data (fifo_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .drained   (drained)
`ifdef FIFO_READER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // FIFO and consumer environment, all activity on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_force)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (rst_n) begin
        if (start && start_cyc < 0) start_cyc = cyc;
        if (fifo_deq) begin
          deq_count++;
          if (first_deq_cyc < 0) first_deq_cyc = cyc;
          if (fifo_q.size() == 0) underflow++;
          else fifo_data = fifo_q.pop_front();
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (held && !(out_valid && out_data == held_data)) unstable++;
        held      = out_valid && !out_ready;
        held_data = out_data;
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
`ifdef FIFO_READER_PARITY_EN
          par_q.push_back(out_parity);
`endif
        end
        if (done) done_count++;
      end else begin
        held = 1'b0;
      end
      if (refill_en && refill_q.size() > 0 && fifo_q.size() < 8)
        fifo_q.push_back(refill_q.pop_front());
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic preload(input logic [DATA_W-1:0] words[$]);
    int waited;
    waited = 0;
    foreach (words[i]) refill_q.push_back(words[i]);
    refill_en = 1'b1;
    while (refill_q.size() > 0 && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    checkOutput("preload_drained", refill_q.size(), 0);
    refill_en = 1'b0;
    tick();
  endtask

  // Expected words: the first len queued words, or every queued word when len=0.
  task automatic applyStimulus(input logic [LEN_W-1:0] len_in, input int ready_mode);
    logic [DATA_W-1:0] avail[$];
    int n;
    avail = {fifo_q, refill_q};
    n = (len_in == 0) ? avail.size() : int'(len_in);
    if (n > avail.size()) n = avail.size();
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(avail[i]);
    exp_left = avail.size() - n;
    got_q = {};
    par_q = {};
    deq_count = 0; done_count = 0; underflow = 0; unstable = 0;
    start_cyc = -1; first_deq_cyc = -1; first_valid_cyc = -1;
    ready_force = ready_mode;
    start = 1'b1;
    len   = len_in;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic finishBurst(input string name);
    int waited;
    waited = 0;
    while (done_count == 0 && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    checkOutput({name, "_done_seen"}, done_count > 0, 1);
    checkOutput({name, "_drained"}, drained, (exp_q.size() > 15) ? 15 : exp_q.size());
    tick();
    tick();
    checkOutput({name, "_busy_idle"}, busy, 0);
    checkOutput({name, "_done_pulses"}, done_count, 1);
    checkOutput({name, "_words"}, got_q.size(), exp_q.size());
    checkOutput({name, "_deq_count"}, deq_count, exp_q.size());
    checkOutput({name, "_underflow"}, underflow, 0);
    checkOutput({name, "_unstable"}, unstable, 0);
    checkOutput({name, "_fifo_left"}, fifo_q.size() + refill_q.size(), exp_left);
    foreach (exp_q[i]) begin
      checkOutput({name, "_word"},
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
`ifdef FIFO_READER_PARITY_EN
      checkOutput({name, "_parity"},
                  (i < par_q.size()) ? 32'(par_q[i]) : 32'hDEAD_BEEF, 32'(^exp_q[i]));
`endif
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w[$];
    logic [LEN_W-1:0]  l;
    int                room, add, waited;

    repeat (3) tick();
    checkOutput("rst_fifo_deq", fifo_deq, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_drained", drained, 0);
`ifdef FIFO_READER_PARITY_EN
    checkOutput("rst_out_parity", out_parity, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Counted burst of 3 from 1,1,4,5,1,4.
    w = {8'd1, 8'd1, 8'd4, 8'd5, 8'd1, 8'd4};
    preload(w);
    applyStimulus(4'd3, 1);
    finishBurst("counted");
    // start_cyc is the CHECK cycle (k+1): deq at k+2, out_valid from k+4.
    checkOutput("lat_deq", first_deq_cyc - start_cyc, 1);
    checkOutput("lat_valid", first_valid_cyc - start_cyc, 3);

    // Until-empty on the leftover 5,1,4, then on a fresh six-word fill.
    applyStimulus(4'd0, 1);
    finishBurst("leftover");
    preload(w);
    applyStimulus(4'd0, 1);
    finishBurst("until_empty");

    // Until-empty on an empty FIFO ends at once.
    applyStimulus(4'd0, 1);
    finishBurst("empty");

    // Backpressure on word 4.
    w = {8'd4, 8'd2};
    preload(w);
    applyStimulus(4'd0, 2);
    waited = 0;
    while (!out_valid && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    checkOutput("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_data", out_data, 4);
      tick();
    end
    checkOutput("bp_deq", deq_count, 1);
    ready_force = 1;
    finishBurst("bp");

    // Counted stall: 7,9 present, 3,8 arrive later; a second start is ignored.
    w = {8'd7, 8'd9};
    preload(w);
    refill_q = {8'd3, 8'd8};
    applyStimulus(4'd4, 1);
    repeat (10) tick();
    checkOutput("stall_busy", busy, 1);
    checkOutput("stall_words", got_q.size(), 2);
    checkOutput("stall_deq", deq_count, 2);
    start = 1'b1;
    len   = 4'd1;
    tick();
    start = 1'b0;
    refill_en = 1'b1;
    finishBurst("stall");
    refill_en = 1'b0;

    // Seventeen words with continuous refill: drained saturates at 15.
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(8'($urandom_range(0, 255)));
    preload(w);
    for (int i = 0; i < 9; i++) refill_q.push_back(8'($urandom_range(0, 255)));
    refill_en = 1'b1;
    applyStimulus(4'd0, 0);
    finishBurst("saturate");
    refill_en = 1'b0;

    // Random fills, lengths and consumer readiness.
    for (int t = 0; t < 8; t++) begin
      room = 8 - fifo_q.size();
      add  = $urandom_range(0, room);
      w = {};
      for (int i = 0; i < add; i++) w.push_back(8'($urandom_range(0, 255)));
      preload(w);
      if ($urandom_range(0, 1) == 1 || fifo_q.size() == 0) l = '0;
      else l = LEN_W'($urandom_range(1, fifo_q.size()));
      applyStimulus(l, 0);
      finishBurst("rand");
    end

    // Drain anything the random loop left behind.
    applyStimulus(4'd0, 1);
    finishBurst("flush");

`ifdef FIFO_READER_PARITY_EN
    w = {8'h01, 8'h03};
    preload(w);
    applyStimulus(4'd0, 1);
    finishBurst("parity");
    checkOutput("par_01", (par_q.size() > 0) ? 32'(par_q[0]) : 32'hDEAD_BEEF, 1);
    checkOutput("par_03", (par_q.size() > 1) ? 32'(par_q[1]) : 32'hDEAD_BEEF, 0);
`endif

    // Reset while presenting 5, with start asserted on the same edge.
    w = {8'd5};
    preload(w);
    applyStimulus(4'd0, 2);
    waited = 0;
    while (!out_valid && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    checkOutput("mid_pre_data", out_data, 5);
    rst_n = 1'b0;
    start = 1'b1;
    len   = 4'd3;
    tick();
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_drained", drained, 0);
    checkOutput("mid_done", done, 0);
    checkOutput("mid_fifo_deq", fifo_deq, 0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    checkOutput("mid_busy_after", busy, 0);
    tick();
    checkOutput("mid_no_done", done_count, 0);
    checkOutput("mid_deq_total", deq_count, 1);
    ready_force = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
